// File: rtl/top_pkg.sv
// Shared constants and the fixed linear-classifier coefficient tables.
// Scores are 20-bit signed; the worst-case magnitude stays near 1000, well inside range.
package top_pkg;

   localparam int NUM_INP   = 5;
   localparam int WIDTH_A   = 8;
   localparam int OUTWIDTH  = 2;
   localparam int NUM_CLASS = 3;
   localparam int SCORE_W   = 20;
   localparam int WEIGHT_W  = 8;

   typedef logic signed [WEIGHT_W-1:0] weight_t;
   typedef logic signed [SCORE_W-1:0]  score_t;
   typedef weight_t                    weight_row_t [NUM_INP];

   // Row k holds the weights of class k; element i multiplies feature i.
   localparam weight_row_t WEIGHT_TBL [NUM_CLASS] = '{
      '{ 8'sd2, -8'sd1,  8'sd0,  8'sd1, -8'sd2},
      '{-8'sd1,  8'sd2,  8'sd1,  8'sd0, -8'sd1},
      '{-8'sd1, -8'sd1,  8'sd1,  8'sd2,  8'sd1}
   };

   localparam score_t BIAS_TBL [NUM_CLASS] = '{
      20'sd0,
      -20'sd16,
      -20'sd32
   };

endpackage

// File: rtl/class_score.sv
// One class score: bias plus the signed dot product of a weight row with the
// unsigned features. Feature 0 sits in the most significant byte of feat.
module class_score
   import top_pkg::*;
(
   input  logic [NUM_INP*WIDTH_A-1:0] feat,
   input  weight_t                    weight [NUM_INP],
   input  score_t                     bias,
   output score_t                     score
);

   score_t acc;

   always_comb begin
      acc = bias;
      for (int i = 0; i < NUM_INP; i++) begin
         // Zero-extend the feature before the signed multiply so 255 stays +255.
         acc = acc + score_t'(weight[i])
                   * score_t'({1'b0, feat[(NUM_INP-1-i)*WIDTH_A +: WIDTH_A]});
      end
   end

   assign score = acc;

endmodule

// File: rtl/top.sv
// Two-stage linear classifier: stage 1 registers the features, stage 2 scores
// all classes combinationally and registers the argmax label.
module top #(
   parameter int NUM_INP  = 5,
   parameter int WIDTH_A  = 8,
   parameter int OUTWIDTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [NUM_INP*WIDTH_A-1:0]  inp,
   output logic [OUTWIDTH-1:0]         out,
   output logic                        out_valid
);

   import top_pkg::*;

   logic [NUM_INP*WIDTH_A-1:0] s1_data;
   logic                       s1_valid;
   score_t                     score [NUM_CLASS];
   score_t                     best_score;
   logic [OUTWIDTH-1:0]        best_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= inp;
         end
      end
   end

   for (genvar k = 0; k < NUM_CLASS; k++) begin : g_score
      class_score u_class_score (
         .feat   (s1_data),
         .weight (WEIGHT_TBL[k]),
         .bias   (BIAS_TBL[k]),
         .score  (score[k])
      );
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx   = '0;
      best_score = score[0];
      for (int k = 1; k < NUM_CLASS; k++) begin
         if (score[k] > best_score) begin
            best_score = score[k];
            best_idx   = OUTWIDTH'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out <= best_idx;
         end
      end
   end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: stimulus pushes expected labels and due cycles,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_top;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [39:0] inp;
   logic [1:0]  out;
   logic        out_valid;

   typedef struct {
      int label;
      int due;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle_cnt = 0;
   int   last_exp = 0;

   localparam int W_REF [3][5] = '{'{2, -1, 0, 1, -2},
                                   '{-1, 2, 1, 0, -1},
                                   '{-1, -1, 1, 2, 1}};
   localparam int B_REF [3] = '{0, -16, -32};

   top dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .inp       (inp),
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cycle_cnt);
      end
   endtask

   // Reference: scores as plain integers, then the first class reaching the maximum.
   function automatic int ref_label(input logic [39:0] v);
      int s [3];
      int mx;
      int f;
      for (int k = 0; k < 3; k++) begin
         s[k] = B_REF[k];
         for (int i = 0; i < 5; i++) begin
            f = int'(v[(4-i)*8 +: 8]);
            s[k] += W_REF[k][i] * f;
         end
      end
      mx = s[0];
      if (s[1] > mx) mx = s[1];
      if (s[2] > mx) mx = s[2];
      for (int k = 0; k < 3; k++) begin
         if (s[k] == mx) return k;
      end
      return -1;
   endfunction

   function automatic logic [39:0] pack5(input int a, input int b, input int c,
                                         input int d, input int e);
      return {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0]};
   endfunction

   // Drive one cycle of stimulus between edges; the next edge captures it.
   task automatic drive(input logic v, input logic [39:0] x, input int exp_label);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      inp      = x;
      if (v) begin
         e.label = exp_label;
         e.due   = cycle_cnt + 2;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom, 0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got out_valid=1 out=%0d, expected no output (cycle %0d)",
                        out, cycle_cnt);
            end else begin
               e = sb_q.pop_front();
               check("label", int'(out), e.label);
               check("latency", cycle_cnt, e.due);
               last_exp = e.label;
            end
         end else begin
            check("hold_out", int'(out), last_exp);
         end
      end
   end

   initial begin
      logic [39:0] x;
      int          n;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      inp      = '1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", int'(out), 0);
      check("reset_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with labels taken straight from the scores worked by hand.
      drive(1'b1, pack5(0, 0, 0, 0, 0), 0);
      idle(2);
      drive(1'b1, pack5(0, 255, 0, 0, 0), 1);
      idle(2);
      drive(1'b1, pack5(0, 0, 0, 255, 255), 2);
      idle(2);
      drive(1'b1, pack5(0, 0, 16, 0, 0), 0);
      idle(2);

      // Streaming: three back-to-back samples yield three back-to-back labels.
      drive(1'b1, pack5(255, 0, 0, 0, 0), 0);
      drive(1'b1, pack5(0, 255, 0, 0, 0), 1);
      drive(1'b1, pack5(0, 0, 0, 255, 255), 2);
      idle(3);

      // Randomized traffic against the reference model.
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < 5; i++) begin
            n = $urandom_range(0, 3);
            x[(4-i)*8 +: 8] = (n == 0) ? 8'd0 : (n == 1) ? 8'd255 : 8'($urandom);
         end
         if ($urandom_range(0, 9) < 7) drive(1'b1, x, ref_label(x));
         else                          drive(1'b0, x, 0);
      end
      idle(3);

      // Mid-pipeline reset: label 2 is on the output and a label-1 sample is in stage 1.
      drive(1'b1, pack5(0, 0, 0, 255, 255), 2);
      drive(1'b1, pack5(0, 255, 0, 0, 0), 1);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      sb_q.delete();
      last_exp = 0;
      #1;
      check("async_reset_out", int'(out), 0);
      check("async_reset_out_valid", int'(out_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      check("held_reset_out", int'(out), 0);
      check("held_reset_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // First sample after release keeps the normal latency.
      drive(1'b1, pack5(0, 0, 0, 255, 255), 2);
      idle(1);
      drive(1'b1, pack5(0, 0, 16, 0, 0), 0);
      idle(1);

      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      check("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter NUM_INP, default 5, number of input features.
REQ-002 Parameter WIDTH_A, default 8, width of each unsigned feature.
REQ-003 Parameter OUTWIDTH, default 2, width of the class label.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  qualifies inp on the current edge.
REQ-008 inp  input  NUM_INP*WIDTH_A (40)  concatenated features; feature 0 in inp[39:32], feature 4 in inp[7:0].
REQ-009 out  output  OUTWIDTH (2)  predicted class label.
REQ-010 out_valid  output  1  high for one cycle per new label in out.

Function
REQ-011 Each feature x_i SHALL be treated as unsigned 0..255.
REQ-012 Three class scores SHALL be computed as S_k = b_k + sum over i of w_k,i * x_i, in signed arithmetic.
REQ-013 Class 0 SHALL use weights (+2,-1,0,+1,-2) and bias 0.
REQ-014 Class 1 SHALL use weights (-1,+2,+1,0,-1) and bias -16.
REQ-015 Class 2 SHALL use weights (-1,-1,+1,+2,+1) and bias -32.
REQ-016 Weights and products SHALL be signed; scores SHALL be at least 20 bits signed so that no overflow occurs over the full input range.
REQ-017 out SHALL be the index k of the maximum S_k.
REQ-018 On ties, the lowest index SHALL win.
REQ-019 Label value 3 SHALL never be produced.
REQ-020 Stage 1: on a rising edge with in_valid=1, inp SHALL be captured; the stage-1 valid bit SHALL follow in_valid every cycle.
REQ-021 Stage 2: scores and argmax SHALL be computed combinationally from stage 1; out and out_valid SHALL be registered.
REQ-022 Latency SHALL be 2 cycles: a sample accepted at edge N yields out at edge N+1 with out_valid=1 after edge N+1.
REQ-023 Throughput SHALL be one sample per cycle; back-to-back in_valid SHALL produce back-to-back out_valid.
REQ-024 When stage-1 valid is 0, out SHALL hold its previous value and out_valid SHALL be 0.

Reset
REQ-025 While rst_n=0, out SHALL be 0, out_valid SHALL be 0, all pipeline valid bits SHALL be 0 and the stage-1 data register SHALL be 0, independent of clk.
REQ-026 A reset asserted mid-pipeline SHALL discard in-flight samples; no out_valid SHALL follow for them after reset is released.
REQ-027 The first sample accepted after reset is released SHALL obey REQ-022.

Structure
REQ-028 A package top_pkg SHALL hold NUM_INP, WIDTH_A, OUTWIDTH, NUM_CLASS=3, SCORE_W=20, the weight table (signed 8-bit) and the bias table (signed SCORE_W).
REQ-029 One sub-module class_score SHALL compute one S_k from the features and one weight/bias row; top SHALL instantiate it NUM_CLASS times, followed by argmax and the registers.

Verification
REQ-030 inp=(0,0,0,0,0), in_valid pulse -> scores (0,-16,-32); out=0, out_valid=1 exactly 2 edges later.
REQ-031 inp=(0,255,0,0,0) -> scores (-255,494,-287); out=1.
REQ-032 inp=(0,0,0,255,255) -> scores (-255,-271,733); out=2.
REQ-033 Tie check: inp=(0,0,16,0,0) -> scores (0,0,-16); out=0.
REQ-034 Streaming: (255,0,0,0,0),(0,255,0,0,0),(0,0,0,255,255) on consecutive cycles -> out 0,1,2 on consecutive cycles, out_valid held high for 3 cycles.
REQ-035 Reset: assert rst_n=0 between clock edges one cycle after a valid input -> out=0 and out_valid=0 immediately, and no out_valid after release until a new in_valid.
